// File: rtl/kong_motion_ctrl.sv
// rtl/kong_motion_ctrl.sv - per-frame motion and state controller for the Kong sprite
// Sub-pixel fixed-point position/velocity, updated once per frame_tick.
module kong_motion_ctrl #(
  parameter int FRAC        = 4,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int KONG_W      = 64,
  parameter int KONG_H      = 48,
  parameter int INIT_X      = 32,
  parameter int INIT_Y      = 400,
  parameter int WALK_SPEED  = 32,
  parameter int CLIMB_SPEED = 16,
  parameter int JUMP_VY     = 128,
  parameter int GRAVITY     = 8,
  parameter int MAX_VY      = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_jump,
  input  logic [3:0]         plat_hit,
  input  logic               rope_hit,
  output logic signed [10:0] top_left_x,
  output logic signed [10:0] top_left_y,
  output logic [3:0]         state,
  output logic [3:0]         icon,
  output logic               direction
);
  localparam int FW = 11 + FRAC;
  localparam int SW = FW + 1;
  typedef logic signed [FW-1:0] fix_t;
  typedef logic signed [SW-1:0] wide_t;

  localparam wide_t XMAX_FX  = wide_t'((SCREEN_W - KONG_W) << FRAC);
  localparam wide_t YMAX_FX  = wide_t'((SCREEN_H - KONG_H) << FRAC);
  localparam wide_t WALK_FX  = wide_t'(WALK_SPEED);
  localparam wide_t CLIMB_FX = wide_t'(CLIMB_SPEED);
  localparam wide_t JUMP_FX  = wide_t'(JUMP_VY);
  localparam wide_t GRAV_FX  = wide_t'(GRAVITY);
  localparam wide_t MAXVY_FX = wide_t'(MAX_VY);
  localparam fix_t  INIT_X_FX = fix_t'(INIT_X << FRAC);
  localparam fix_t  INIT_Y_FX = fix_t'(INIT_Y << FRAC);

  localparam int E_LEFT   = 3;
  localparam int E_TOP    = 2;
  localparam int E_RIGHT  = 1;
  localparam int E_BOTTOM = 0;

  typedef enum logic [3:0] {
    KONG_IS_STANDING            = 4'd0,
    KONG_IS_JUMPING             = 4'd1,
    KONG_IS_JUMPING_IN_PLATFORM = 4'd2,
    KONG_IS_CLIMBING            = 4'd3,
    KONG_IS_JUMPING_FROM_ROPE   = 4'd4
  } kong_state_t;

  localparam logic [3:0] KONG_STAND       = 4'd0;
  localparam logic [3:0] KONG_WALK_LEFT   = 4'd1;
  localparam logic [3:0] KONG_WALK_RIGHT  = 4'd2;
  localparam logic [3:0] KONG_CLIMB_LEFT  = 4'd3;
  localparam logic [3:0] KONG_CLIMB_RIGHT = 4'd4;
  localparam logic [3:0] KONG_JUMP_LEFT   = 4'd5;
  localparam logic [3:0] KONG_JUMP_RIGHT  = 4'd6;
  localparam logic       KONG_LOOK_RIGHT  = 1'b0;
  localparam logic       KONG_LOOK_LEFT   = 1'b1;

  fix_t        x, y, vx, vy;
  kong_state_t st;
  logic [3:0]  icon_r;
  logic        dir_r;
  logic [3:0]  plat_seen;
  logic        rope_seen;
  logic        jump_prev;

  logic [3:0]  plat;
  logic        rope, jump_edge, go_left, go_right, air, land, dir_n;
  wide_t       step_x, vx_a, vy_a, vy_g, x_sum, y_sum;
  fix_t        x_n, y_n, vx_n, vy_n;
  kong_state_t st_n;
  logic [3:0]  icon_n;

  always_comb begin
    plat      = plat_seen | plat_hit;
    rope      = rope_seen | rope_hit;
    jump_edge = btn_jump & ~jump_prev;
    go_right  = btn_right & ~btn_left;
    go_left   = btn_left & ~btn_right;
    step_x    = go_right ? WALK_FX : (go_left ? -WALK_FX : '0);
    dir_n     = go_left ? KONG_LOOK_LEFT : (go_right ? KONG_LOOK_RIGHT : dir_r);
    st_n      = st;
    x_sum     = wide_t'(x);
    y_sum     = wide_t'(y);
    vx_a      = wide_t'(vx);
    vy_a      = wide_t'(vy);
    vy_g      = '0;
    vx_n      = vx;
    vy_n      = vy;
    air       = 1'b0;
    land      = 1'b0;

    // Leaving the ground applies the first airborne step in the same frame.
    case (st)
      KONG_IS_STANDING: begin
        vx_a = '0;
        vy_a = '0;
        if (jump_edge) begin
          st_n = KONG_IS_JUMPING;
          vx_a = step_x;
          vy_a = -JUMP_FX;
          air  = 1'b1;
        end else begin
          x_sum = x_sum + step_x;
          if (btn_up && rope) begin
            st_n = KONG_IS_CLIMBING;
          end else if (!plat[E_BOTTOM] && (y_sum < YMAX_FX)) begin
            st_n = KONG_IS_JUMPING;
            air  = 1'b1;
          end
        end
      end
      KONG_IS_CLIMBING: begin
        vx_a = '0;
        vy_a = '0;
        if (jump_edge) begin
          st_n = KONG_IS_JUMPING_FROM_ROPE;
          vx_a = step_x;
          vy_a = -JUMP_FX;
          air  = 1'b1;
        end else if (!rope) begin
          st_n = KONG_IS_JUMPING;
          air  = 1'b1;
        end else if (btn_up && !btn_down) begin
          y_sum = y_sum - CLIMB_FX;
        end else if (btn_down && !btn_up) begin
          y_sum = y_sum + CLIMB_FX;
        end
      end
      default: begin
        air = 1'b1;
        if (plat[E_LEFT] || plat[E_RIGHT]) vx_a = '0;
        if (plat[E_TOP] && vy[FW-1]) vy_a = '0;
      end
    endcase

    if (air) begin
      x_sum = x_sum + vx_a;
      y_sum = y_sum + vy_a;
      vy_g  = vy_a + GRAV_FX;
      vx_n  = fix_t'(vx_a);
      vy_n  = fix_t'((vy_g > MAXVY_FX) ? MAXVY_FX : vy_g);
    end

    case (st)
      KONG_IS_JUMPING: begin
        if (!vy_a[SW-1] && plat[E_BOTTOM]) begin
          land = 1'b1;
        end else if (vy_a[SW-1] && (plat != 4'd0)) begin
          st_n = KONG_IS_JUMPING_IN_PLATFORM;
        end else if (btn_up && rope) begin
          st_n = KONG_IS_CLIMBING;
          vx_n = '0;
          vy_n = '0;
        end
      end
      KONG_IS_JUMPING_IN_PLATFORM: begin
        if (plat == 4'd0) st_n = KONG_IS_JUMPING;
      end
      KONG_IS_JUMPING_FROM_ROPE: begin
        if (!vy_a[SW-1] && plat[E_BOTTOM]) land = 1'b1;
        else if (!rope) st_n = KONG_IS_JUMPING;
      end
      default: ;
    endcase
    if (air && (y_sum >= YMAX_FX)) land = 1'b1;

    if (x_sum[SW-1])          x_n = '0;
    else if (x_sum > XMAX_FX) x_n = fix_t'(XMAX_FX);
    else                      x_n = fix_t'(x_sum);
    if (y_sum[SW-1])          y_n = '0;
    else if (y_sum > YMAX_FX) y_n = fix_t'(YMAX_FX);
    else                      y_n = fix_t'(y_sum);

    if (land) begin
      st_n = KONG_IS_STANDING;
      vx_n = '0;
      vy_n = '0;
      y_n[FRAC-1:0] = '0;
    end

    case (st_n)
      KONG_IS_STANDING: icon_n = go_left ? KONG_WALK_LEFT : (go_right ? KONG_WALK_RIGHT : KONG_STAND);
      KONG_IS_CLIMBING: icon_n = (dir_n == KONG_LOOK_LEFT) ? KONG_CLIMB_LEFT : KONG_CLIMB_RIGHT;
      default:          icon_n = (dir_n == KONG_LOOK_LEFT) ? KONG_JUMP_LEFT : KONG_JUMP_RIGHT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= INIT_X_FX;
      y         <= INIT_Y_FX;
      vx        <= '0;
      vy        <= '0;
      st        <= KONG_IS_STANDING;
      icon_r    <= KONG_STAND;
      dir_r     <= KONG_LOOK_RIGHT;
      plat_seen <= '0;
      rope_seen <= 1'b0;
      jump_prev <= 1'b0;
    end else if (frame_tick) begin
      x         <= x_n;
      y         <= y_n;
      vx        <= vx_n;
      vy        <= vy_n;
      st        <= st_n;
      icon_r    <= icon_n;
      dir_r     <= dir_n;
      plat_seen <= '0;
      rope_seen <= 1'b0;
      jump_prev <= btn_jump;
    end else begin
      plat_seen <= plat_seen | plat_hit;
      rope_seen <= rope_seen | rope_hit;
    end
  end

  assign top_left_x = x[FW-1:FRAC];
  assign top_left_y = y[FW-1:FRAC];
  assign state      = st;
  assign icon       = icon_r;
  assign direction  = dir_r;
endmodule
